clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
Runtime-programmable clock-enable/divided-clock generator and sequencer for the fabric clock dividers (default 50 MHz -> 2 MHz). It owns divider start/stop sequencing and divisor reconfiguration. Every change is applied only at an output period boundary, so downstream sample/ADC logic never sees a runt pulse. Software/FSM requesters change the divisor through a req/ack handshake.

Parameters:
DIV_W, 8, width of divisor and internal counter
DIV_DEFAULT, 25, divisor loaded at reset (50 MHz / 25 = 2 MHz); must be >= 2

Ports:
clk_50m  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset, clears all state immediately
start  in  1  1-cycle pulse: begin output generation
stop  in  1  1-cycle pulse: stop after current period completes
div_req  in  1  divisor change request, held high until div_ack
div_val  in  DIV_W  requested divisor, stable while div_req high
div_ack  out  1  1-cycle pulse: request consumed (loaded or rejected)
div_err  out  1  1-cycle pulse coincident with div_ack when div_val < 2 (not loaded)
div_cur  out  DIV_W  divisor currently in effect
clk_out  out  1  registered divided clock
clk_en  out  1  registered 1-cycle pulse on first cycle of each output period
running  out  1  high in RUN and STOP_PEND

Behaviour:
- Reset values: clk_out=0, clk_en=0, running=0, div_ack=0, div_err=0, div_cur=DIV_DEFAULT, cnt=0, state=IDLE.
- Period of divisor N = N cycles. clk_out=1 for the first ceil(N/2) cycles and 0 for the remaining floor(N/2). clk_en=1 only on cycle 0 of each period.
  - N=2: 1 cycle high, 1 cycle low.
  - N=3: 2 cycles high, 1 cycle low.
- Internal cnt runs 0..N-1. Cycle N-1 is the boundary cycle; cnt wraps to 0 on the following edge.
- States:
  - IDLE: clk_out=0, clk_en=0, cnt held at 0.
    - start sampled -> RUN. Period cycle 0 (clk_out=1, clk_en=1) appears on the next cycle (latency 1).
    - start and stop in the same cycle: stop wins, remain IDLE.
  - RUN: free-running periods.
    - stop sampled -> STOP_PEND.
    - start ignored.
  - STOP_PEND: current period completes unchanged.
    - At the boundary cycle -> IDLE. The next cycle has clk_out=0 and no clk_en.
    - start sampled before the boundary cancels the stop -> RUN, with no disturbance to the waveform.
    - stop is ignored here.
- Divisor handshake:
  - IDLE: div_req sampled -> next cycle div_cur<=div_val and div_ack=1.
  - RUN/STOP_PEND: request held pending.
    - On the boundary cycle, div_cur is loaded, so the next period uses the new N.
    - div_ack pulses on that next cycle (the new period's cycle 0).
    - Exactly one ack per request. div_req must drop the cycle after div_ack; if it is still high, it is treated as a new request.
  - div_val < 2: div_ack and div_err pulse at the same point, and div_cur is unchanged.
  - div_val == div_cur: normal load and ack; waveform unchanged.
  - start and div_req together in IDLE: the divisor loads in the same edge, so the first period uses the new N.
  - Pending request when stop completes to IDLE: loaded at that boundary as above.
- cnt compares against div_cur only, never against div_val directly.
- Reset asserted mid-period: all outputs forced to reset values asynchronously. Any pending request is dropped with no ack; the requester must re-issue.

Test Plan:
- Reset, start pulse -> 1 cycle later clk_en=1. clk_out high 13 cycles, low 12, period 25; clk_en every 25 cycles; running=1.
- In RUN with N=25, div_req div_val=10 at period cycle 5 -> no change until cycle 24. Next period is 10 cycles (5 high, 5 low); div_ack coincides with its clk_en.
- div_req div_val=1 (and separately 0) -> div_ack+div_err pulse at the next boundary; div_cur stays 25 and the period stays 25.
- stop at period cycle 3 -> current period completes (13 high, 12 low), then clk_out=0 with no clk_en and running=0. Repeat with stop then start at cycle 8 -> waveform continues uninterrupted.
- IDLE with simultaneous start+stop -> stays IDLE. IDLE with start+div_req div_val=2 -> toggles 1-high/1-low, ack on the first clk_en cycle.
- rst_n low during high phase with a request pending -> all outputs 0 immediately, div_cur=25, and no ack after release.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Runtime-programmable divided clock / clock-enable generator with start/stop
// sequencing and a req/ack divisor change handshake. All changes take effect
// only at an output period boundary, so downstream logic never sees a runt
// pulse or a truncated period.
//
// Ports:
//   clk_50m  in   system clock, all logic on rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   1-cycle pulse: begin output generation
//   stop     in   1-cycle pulse: stop after the current period completes
//   div_req  in   divisor change request, held high until div_ack
//   div_val  in   requested divisor, stable while div_req is high
//   div_ack  out  1-cycle pulse: request consumed (loaded or rejected)
//   div_err  out  1-cycle pulse with div_ack when div_val < 2 (not loaded)
//   div_cur  out  divisor currently in effect
//   clk_out  out  registered divided clock, high for ceil(N/2) of N cycles
//   clk_en   out  registered pulse on cycle 0 of every output period
//   running  out  high while generating (RUN or STOP_PEND)
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 25
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic [DIV_W-1:0] div_cur,
  output logic             clk_out,
  output logic             clk_en,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic             running_q, running_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;

  logic             active;
  logic             boundary;
  logic             req_take;
  logic             req_bad;
  logic [DIV_W:0]   high_len;   // ceil(N/2) for the divisor of the next cycle

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    clk_out_d = 1'b0;
    clk_en_d  = 1'b0;
    div_ack_d = 1'b0;
    div_err_d = 1'b0;

    active   = (state_q != ST_IDLE);
    // cnt only ever compares against the divisor in effect, never div_val.
    boundary = active && (cnt_q == (div_cur_q - ONE));
    // A request is ignored during its own ack cycle (div_req is still high
    // then); if it stays high one cycle longer it counts as a new request.
    req_take = div_req && !div_ack_q && (!active || boundary);
    req_bad  = (div_val < DIV_MIN);

    if (req_take) begin
      div_ack_d = 1'b1;
      div_err_d = req_bad;
      if (!req_bad) begin
        div_cur_d = div_val;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // start together with stop: stop wins.
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = boundary ? '0 : cnt_q + ONE;
        if (stop) begin
          state_d = ST_STOP_PEND;
        end
      end
      ST_STOP_PEND: begin
        // The boundary ends the period and takes precedence over a late start.
        if (boundary) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
          if (start) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    running_d = (state_d != ST_IDLE);
    high_len  = ({1'b0, div_cur_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    if (running_d) begin
      clk_en_d  = (cnt_d == '0);
      clk_out_d = ({1'b0, cnt_d} < high_len);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  // NOTE: reset is asynchronous; all outputs drop immediately and a pending
  // request is simply forgotten (div_ack_q cleared, nothing remembered).
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_cur_q <= DIV_RST;
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
      running_q <= 1'b0;
      div_ack_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
      running_q <= running_d;
      div_ack_q <= div_ack_d;
      div_err_q <= div_err_d;
    end
  end

  assign div_ack = div_ack_q;
  assign div_err = div_err_q;
  assign div_cur = div_cur_q;
  assign clk_out = clk_out_q;
  assign clk_en  = clk_en_q;
  assign running = running_q;

endmodule
